// File: rtl/bcd_countdown_core.sv
// Parametrised BCD countdown with in-place digit editor and IDLE/EDIT/RUN/PAUSE/DONE control.
// All outputs registered, one cycle after the sampling edge; no backpressure, same-cycle buttons resolve by fixed priority.
module bcd_countdown_core #(
   parameter int                  N_DIGITS = 9,
   parameter logic [N_DIGITS-1:0] SIX_MASK = 9'b001010000,
   parameter int                  EDIT_LO  = 3,
   parameter bit                  RELOAD   = 1'b0,
   localparam int                 CW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
   localparam int                 W        = 4 * N_DIGITS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick_i,
   input  logic          btn_start,
   input  logic          btn_left,
   input  logic          btn_right,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_clear,
   output logic [W-1:0]  count_o,
   output logic [CW-1:0] cursor_o,
   output logic          edit_o,
   output logic          run_o,
   output logic          done_o,
   output logic          expire_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_EDIT  = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [CW-1:0] CUR_TOP = CW'(N_DIGITS - 1);
   localparam logic [CW-1:0] CUR_LO  = CW'(EDIT_LO);
   localparam logic [W-1:0]  ONE     = W'(1);

   state_t        r_state, w_state_nxt;
   logic [W-1:0]  r_count, w_count_nxt;
   logic [W-1:0]  r_preset, w_preset_nxt;
   logic [CW-1:0] r_cursor, w_cursor_nxt;
   logic [W-1:0]  w_dec, w_edit_ent, w_count_edit;
   logic [3:0]    w_cur_dig, w_cur_max, w_cur_new;
   logic          w_nz, w_one;
   logic          r_edit, r_run, r_done, r_expire;

   function automatic logic [3:0] dig_max(input int i);
      return SIX_MASK[i] ? 4'd5 : 4'd9;
   endfunction

   assign w_nz  = |r_count;
   assign w_one = (r_count == ONE);

   // Ripple borrow: a zero digit wraps to its own max and passes the borrow up.
   always_comb begin : dec_chain
      logic w_brw;
      w_brw = 1'b1;
      w_dec = r_count;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (w_brw) begin
            if (r_count[4*i +: 4] == 4'd0) begin
               w_dec[4*i +: 4] = dig_max(i);
            end else begin
               w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
               w_brw           = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_edit_ent = r_count;
      for (int i = 0; i < EDIT_LO; i++) begin
         w_edit_ent[4*i +: 4] = 4'd0;
      end
   end

   always_comb begin
      w_cur_dig = 4'd0;
      w_cur_max = 4'd9;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (r_cursor == CW'(i)) begin
            w_cur_dig = r_count[4*i +: 4];
            w_cur_max = dig_max(i);
         end
      end
   end

   always_comb begin
      if (btn_up) begin
         w_cur_new = (w_cur_dig >= w_cur_max) ? 4'd0 : w_cur_dig + 4'd1;
      end else begin
         w_cur_new = (w_cur_dig == 4'd0) ? w_cur_max : w_cur_dig - 4'd1;
      end
      w_count_edit = r_count;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (r_cursor == CW'(i)) begin
            w_count_edit[4*i +: 4] = w_cur_new;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_cursor_nxt = r_cursor;
      w_preset_nxt = r_preset;
      case (r_state)
         S_IDLE: begin
            if (btn_clear) begin
               w_count_nxt = '0;
            end else if (btn_start) begin
               if (w_nz) begin
                  w_state_nxt  = S_RUN;
                  w_preset_nxt = r_count;
               end
            end else if (btn_left || btn_right) begin
               w_state_nxt  = S_EDIT;
               w_cursor_nxt = CUR_TOP;
               w_count_nxt  = w_edit_ent;
            end
         end
         S_EDIT: begin
            if (btn_clear) begin
               w_count_nxt = '0;
            end else if (btn_start) begin
               if (w_nz) begin
                  w_state_nxt  = S_RUN;
                  w_preset_nxt = r_count;
                  w_cursor_nxt = CUR_TOP;
               end
            end else if (btn_left) begin
               if (r_cursor == CUR_TOP) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cursor_nxt = r_cursor + CW'(1);
               end
            end else if (btn_right) begin
               if (r_cursor == CUR_LO) begin
                  w_state_nxt  = S_IDLE;
                  w_cursor_nxt = CUR_TOP;
               end else begin
                  w_cursor_nxt = r_cursor - CW'(1);
               end
            end else if (btn_up || btn_down) begin
               w_count_nxt = w_count_edit;
            end
         end
         S_RUN: begin
            if (btn_clear) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = '0;
            end else if (btn_start) begin
               w_state_nxt = S_PAUSE;
            end else if (tick_i) begin
               if (w_one) begin
                  w_state_nxt = S_DONE;
                  w_count_nxt = '0;
               end else begin
                  w_count_nxt = w_dec;
               end
            end
         end
         S_PAUSE: begin
            if (btn_clear) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = '0;
            end else if (btn_start) begin
               w_state_nxt = S_RUN;
            end else if (btn_left || btn_right) begin
               w_state_nxt  = S_EDIT;
               w_cursor_nxt = CUR_TOP;
               w_count_nxt  = w_edit_ent;
            end
         end
         S_DONE: begin
            if (btn_clear) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = '0;
            end else if (RELOAD || btn_start) begin
               w_state_nxt = S_RUN;
               w_count_nxt = r_preset;
            end else if (btn_left || btn_right) begin
               w_state_nxt  = S_EDIT;
               w_cursor_nxt = CUR_TOP;
               w_count_nxt  = w_edit_ent;
            end
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_count_nxt  = '0;
            w_cursor_nxt = CUR_TOP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_preset <= '0;
         r_cursor <= CUR_TOP;
         r_edit   <= 1'b0;
         r_run    <= 1'b0;
         r_done   <= 1'b0;
         r_expire <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_preset <= w_preset_nxt;
         r_cursor <= w_cursor_nxt;
         r_edit   <= (w_state_nxt == S_EDIT);
         r_run    <= (w_state_nxt == S_RUN);
         r_done   <= (w_state_nxt == S_DONE);
         r_expire <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
      end
   end

   assign count_o  = r_count;
   assign cursor_o = r_cursor;
   assign edit_o   = r_edit;
   assign run_o    = r_run;
   assign done_o   = r_done;
   assign expire_o = r_expire;

endmodule

// File: tb/tb_bcd_countdown_core.sv
// Directed bench for bcd_countdown_core: table of per-cycle vectors plus sequences for expiry, reload and reset.
module tb_bcd_countdown_core;

   localparam logic [5:0] B_NO  = 6'b000000;
   localparam logic [5:0] B_CLR = 6'b100000;
   localparam logic [5:0] B_STA = 6'b010000;
   localparam logic [5:0] B_LFT = 6'b001000;
   localparam logic [5:0] B_RGT = 6'b000100;
   localparam logic [5:0] B_UP  = 6'b000010;
   localparam logic [5:0] B_DN  = 6'b000001;
   localparam logic [3:0] CUR_X = 4'hF;

   typedef struct {
      string       nm;
      logic        rst;
      logic        tick;
      logic [5:0]  btn;
      logic [35:0] cnt;
      logic [3:0]  cur;
      logic [3:0]  flags;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0, tick_i = 1'b0;
   logic btn_start = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic btn_up = 1'b0, btn_down = 1'b0, btn_clear = 1'b0;

   logic [35:0] count_a, count_b, count_c;
   logic [3:0]  cur_a, cur_b, cur_c;
   logic        edit_a, run_a, done_a, exp_a;
   logic        edit_b, run_b, done_b, exp_b;
   logic        edit_c, run_c, done_c, exp_c;

   int   n_chk = 0;
   int   n_fail = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   bcd_countdown_core u_a (
      .clk(clk), .rst(rst), .tick_i(tick_i), .btn_start(btn_start), .btn_left(btn_left),
      .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
      .count_o(count_a), .cursor_o(cur_a), .edit_o(edit_a), .run_o(run_a),
      .done_o(done_a), .expire_o(exp_a));

   bcd_countdown_core #(.EDIT_LO(0), .RELOAD(1'b0)) u_b (
      .clk(clk), .rst(rst), .tick_i(tick_i), .btn_start(btn_start), .btn_left(btn_left),
      .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
      .count_o(count_b), .cursor_o(cur_b), .edit_o(edit_b), .run_o(run_b),
      .done_o(done_b), .expire_o(exp_b));

   bcd_countdown_core #(.EDIT_LO(0), .RELOAD(1'b1)) u_c (
      .clk(clk), .rst(rst), .tick_i(tick_i), .btn_start(btn_start), .btn_left(btn_left),
      .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
      .count_o(count_c), .cursor_o(cur_c), .edit_o(edit_c), .run_o(run_c),
      .done_o(done_c), .expire_o(exp_c));

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic t, input logic [5:0] b);
      @(negedge clk);
      rst    = r;
      tick_i = t;
      {btn_clear, btn_start, btn_left, btn_right, btn_up, btn_down} = b;
      @(posedge clk);
      #1;
   endtask

   task automatic v(input string nm, input logic r, input logic t, input logic [5:0] b,
                    input logic [35:0] c, input logic [3:0] cu, input logic [3:0] f);
      vec_t e;
      e.nm = nm; e.rst = r; e.tick = t; e.btn = b; e.cnt = c; e.cur = cu; e.flags = f;
      tbl.push_back(e);
   endtask

   initial begin
      // flags = {edit, run, done, expire}
      v("reset",        1, 0, B_NO,          36'h000000000, 4'd8,  4'b0000);
      v("idle_up_ign",  0, 0, B_UP,          36'h000000000, 4'd8,  4'b0000);
      v("enter_edit",   0, 0, B_RGT,         36'h000000000, 4'd8,  4'b1000);
      v("d8_down_wrap", 0, 0, B_DN,          36'h900000000, 4'd8,  4'b1000);
      v("cur7",         0, 0, B_RGT,         36'h900000000, 4'd7,  4'b1000);
      v("cur6",         0, 0, B_RGT,         36'h900000000, 4'd6,  4'b1000);
      v("d6_up1",       0, 0, B_UP,          36'h901000000, 4'd6,  4'b1000);
      v("d6_up2",       0, 0, B_UP,          36'h902000000, 4'd6,  4'b1000);
      v("d6_up3",       0, 0, B_UP,          36'h903000000, 4'd6,  4'b1000);
      v("d6_up4",       0, 0, B_UP,          36'h904000000, 4'd6,  4'b1000);
      v("d6_up5",       0, 0, B_UP,          36'h905000000, 4'd6,  4'b1000);
      v("d6_up_wrap",   0, 0, B_UP,          36'h900000000, 4'd6,  4'b1000);
      v("d6_down_wrap", 0, 0, B_DN,          36'h905000000, 4'd6,  4'b1000);
      v("cur5",         0, 0, B_RGT,         36'h905000000, 4'd5,  4'b1000);
      v("cur4",         0, 0, B_RGT,         36'h905000000, 4'd4,  4'b1000);
      v("cur3",         0, 0, B_RGT,         36'h905000000, 4'd3,  4'b1000);
      v("right_exit",   0, 0, B_RGT,         36'h905000000, 4'd8,  4'b0000);
      v("idle_clear",   0, 0, B_CLR,         36'h000000000, 4'd8,  4'b0000);
      v("left_entry",   0, 0, B_LFT,         36'h000000000, 4'd8,  4'b1000);
      v("c7",           0, 0, B_RGT,         36'h000000000, 4'd7,  4'b1000);
      v("c6",           0, 0, B_RGT,         36'h000000000, 4'd6,  4'b1000);
      v("c5",           0, 0, B_RGT,         36'h000000000, 4'd5,  4'b1000);
      v("d5_up",        0, 0, B_UP,          36'h000100000, 4'd5,  4'b1000);
      v("edit_clear",   0, 0, B_CLR,         36'h000000000, 4'd5,  4'b1000);
      v("d5_up_again",  0, 0, B_UP,          36'h000100000, 4'd5,  4'b1000);
      v("start_run",    0, 0, B_STA,         36'h000100000, CUR_X, 4'b0100);
      v("borrow_chain", 0, 1, B_NO,          36'h000059999, CUR_X, 4'b0100);
      v("start_tick",   0, 1, B_STA,         36'h000059999, CUR_X, 4'b0000);
      v("pause_tick",   0, 1, B_NO,          36'h000059999, CUR_X, 4'b0000);
      v("resume",       0, 0, B_STA,         36'h000059999, CUR_X, 4'b0100);
      v("run_left_ign", 0, 1, B_LFT,         36'h000059998, CUR_X, 4'b0100);
      v("b2b_tick",     0, 1, B_NO,          36'h000059997, CUR_X, 4'b0100);
      v("clear_start",  0, 0, B_CLR | B_STA, 36'h000000000, CUR_X, 4'b0000);
      v("start_zero",   0, 0, B_STA,         36'h000000000, CUR_X, 4'b0000);

      foreach (tbl[k]) begin
         cyc(tbl[k].rst, tbl[k].tick, tbl[k].btn);
         chk({tbl[k].nm, " count"}, count_a, tbl[k].cnt);
         if (tbl[k].cur != CUR_X) chk({tbl[k].nm, " cursor"}, {32'd0, cur_a}, {32'd0, tbl[k].cur});
         chk({tbl[k].nm, " flags"}, {32'd0, edit_a, run_a, done_a, exp_a}, {32'd0, tbl[k].flags});
      end

      // Expiry with preset 3 on fully editable instances (b: hold, c: auto-reload)
      cyc(1, 0, B_NO);
      cyc(0, 0, B_RGT);
      for (int i = 0; i < 8; i++) cyc(0, 0, B_RGT);
      chk("b cursor0", {32'd0, cur_b}, 36'd0);
      for (int i = 0; i < 3; i++) cyc(0, 0, B_UP);
      chk("b preset3", count_b, 36'h000000003);
      cyc(0, 0, B_STA);
      chk("b run", {35'd0, run_b}, 36'd1);
      cyc(0, 1, B_NO);
      chk("b tick1", count_b, 36'h000000002);
      cyc(0, 1, B_NO);
      chk("b tick2", count_b, 36'h000000001);
      chk("b no early expire", {34'd0, done_b, exp_b}, 36'd0);
      cyc(0, 1, B_NO);
      chk("b expired", count_b, 36'd0);
      chk("b done flags", {32'd0, edit_b, run_b, done_b, exp_b}, {32'd0, 4'b0011});
      chk("c done flags", {32'd0, edit_c, run_c, done_c, exp_c}, {32'd0, 4'b0011});
      chk("c expired", count_c, 36'd0);
      cyc(0, 0, B_NO);
      chk("b hold done", {32'd0, edit_b, run_b, done_b, exp_b}, {32'd0, 4'b0010});
      chk("b hold zero", count_b, 36'd0);
      chk("c reloaded", count_c, 36'h000000003);
      chk("c reload flags", {32'd0, edit_c, run_c, done_c, exp_c}, {32'd0, 4'b0100});
      cyc(0, 1, B_NO);
      chk("b ignores tick in done", {32'd0, edit_b, run_b, done_b, exp_b}, {32'd0, 4'b0010});
      chk("c counting after reload", count_c, 36'h000000002);
      cyc(0, 0, B_STA);
      chk("b restart count", count_b, 36'h000000003);
      chk("b restart flags", {32'd0, edit_b, run_b, done_b, exp_b}, {32'd0, 4'b0100});

      // Reset in the middle of RUN at 1234
      cyc(1, 0, B_NO);
      cyc(0, 0, B_RGT);
      for (int i = 0; i < 5; i++) cyc(0, 0, B_RGT);
      cyc(0, 0, B_UP);
      cyc(0, 0, B_RGT);
      for (int i = 0; i < 2; i++) cyc(0, 0, B_UP);
      cyc(0, 0, B_RGT);
      for (int i = 0; i < 3; i++) cyc(0, 0, B_UP);
      cyc(0, 0, B_RGT);
      for (int i = 0; i < 4; i++) cyc(0, 0, B_UP);
      chk("b edit 1234", count_b, 36'h000001234);
      cyc(0, 0, B_STA);
      chk("b run 1234", {35'd0, run_b}, 36'd1);
      cyc(1, 1, B_STA | B_LFT);
      chk("b rst count", count_b, 36'd0);
      chk("b rst cursor", {32'd0, cur_b}, 36'd8);
      chk("b rst flags", {32'd0, edit_b, run_b, done_b, exp_b}, 36'd0);
      cyc(0, 0, B_NO);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
